// File: rtl/mac_result_collector.sv
// mac_result_collector
// Collects per-lane accumulator results from mac_array, requantizes each lane
// to W bits (arithmetic shift, optional ReLU, saturation), assembles a packed
// row once every lane has reported, and queues rows in a first-word-fall-through
// FIFO drained over a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   acc_in_0..acc_in_3       signed lane accumulators, ACC_W bits each
//   valid_in[N_MACS]         per-lane single-cycle capture strobes
//   relu_en                  clamp negative lane results to 0 (sampled per capture)
//   out_data[N_MACS*W]       head row, lane i in bits [i*W +: W]
//   out_valid / out_ready    row handshake (out_valid = FIFO non-empty)
//   count                    rows held in the FIFO
//   full                     count == DEPTH
//   overflow                 sticky: a completed row was dropped
//   dup_err                  sticky: a lane was strobed twice within one row
module mac_result_collector #(
    parameter int unsigned W      = 8,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned N_MACS = 4,
    parameter int unsigned SHIFT  = 0,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ACC_W-1:0]            acc_in_0,
    input  logic [ACC_W-1:0]            acc_in_1,
    input  logic [ACC_W-1:0]            acc_in_2,
    input  logic [ACC_W-1:0]            acc_in_3,
    input  logic [N_MACS-1:0]           valid_in,
    input  logic                        relu_en,
    output logic [N_MACS*W-1:0]         out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        overflow,
    output logic                        dup_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ROW_W = N_MACS * W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (W - 1)) - 1);
    // -2^(W-1) is the bitwise complement of 2^(W-1)-1 in two's complement
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    // Shift (floor), optional ReLU, then saturate to the signed W-bit range
    function automatic logic [W-1:0] requant(input logic signed [ACC_W-1:0] acc,
                                             input logic relu);
        logic signed [ACC_W-1:0] s;
        s = acc >>> SHIFT;
        if (relu && s[ACC_W-1]) begin
            s = '0;
        end
        if (s > SAT_MAX) begin
            return SAT_MAX[W-1:0];
        end else if (s < SAT_MIN) begin
            return SAT_MIN[W-1:0];
        end
        return s[W-1:0];
    endfunction

    logic signed [ACC_W-1:0] acc_c [N_MACS];
    logic [W-1:0]            rq_c  [N_MACS];
    logic [W-1:0]            lane_q [N_MACS];
    logic [W-1:0]            lane_d [N_MACS];
    logic [N_MACS-1:0]       got_q, got_d;
    logic [ROW_W-1:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    ovf_q, ovf_d, dup_q, dup_d;
    logic [ROW_W-1:0]        row_c;
    logic                    complete_c, push_c, pop_c;

    assign acc_c[0] = acc_in_0;
    assign acc_c[1] = acc_in_1;
    assign acc_c[2] = acc_in_2;
    assign acc_c[3] = acc_in_3;

    // Lane capture, row completion and FIFO bookkeeping
    always_comb begin
        lane_d     = lane_q;
        row_c      = '0;
        got_d      = got_q | valid_in;
        dup_d      = dup_q | (|(got_q & valid_in));
        complete_c = &(got_q | valid_in);
        pop_c      = out_valid && out_ready;
        // a pop in the same edge frees the slot the push needs
        push_c     = complete_c && ((count_q != DEPTH_C) || pop_c);
        ovf_d      = ovf_q | (complete_c & ~push_c);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        for (int i = 0; i < int'(N_MACS); i++) begin
            rq_c[i] = requant(acc_c[i], relu_en);
            if (valid_in[i]) begin
                lane_d[i] = rq_c[i];
            end
            row_c[i*W +: W] = lane_d[i];
        end
        if (complete_c) begin
            got_d = '0;
        end
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_MACS); i++) begin
                lane_q[i] <= '0;
            end
            for (int j = 0; j < int'(DEPTH); j++) begin
                mem_q[j] <= '0;
            end
            got_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            dup_q    <= 1'b0;
        end else begin
            lane_q   <= lane_d;
            got_q    <= got_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            dup_q    <= dup_d;
            if (push_c) begin
                mem_q[wr_ptr_q] <= row_c;
            end
        end
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign full      = (count_q == DEPTH_C);
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign dup_err   = dup_q;

endmodule
